// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice: FSM state
// encoding, NOP opcode and register-index width.
package pipeline_ctrl_pkg;

   localparam int REG_IDX_W   = 3;
   localparam int OPCODE_W    = 5;
   localparam int FLUSH_CNT_W = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP = 5'b00000;

   typedef enum logic [1:0] {
      CTRL_RUN      = 2'd0,
      CTRL_MEM_WAIT = 2'd1,
      CTRL_FLUSH    = 2'd2
   } ctrl_state_e;

   // A NOP reads no registers, so it can never be the victim of a load-use hazard.
   function automatic logic load_use_hit(
      input logic                 ex_mem_read,
      input logic [REG_IDX_W-1:0] ex_rd,
      input logic [OPCODE_W-1:0]  opcode,
      input logic [REG_IDX_W-1:0] rs,
      input logic [REG_IDX_W-1:0] rd
   );
      return ex_mem_read && (opcode != OP_NOP) && ((ex_rd == rs) || (ex_rd == rd));
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters;
// clr has priority and the count sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: sequences PC, fetch/decode and
// decode/execute enables and flushes for load-use, branch and memory stalls.
module hazard_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OPCODE_W-1:0]  opcode_decode,
   input  logic [REG_IDX_W-1:0] Rs_decode,
   input  logic [REG_IDX_W-1:0] Rd_decode,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_Rd,
   input  logic                 branch_taken,
   input  logic                 mem_busy,
   output logic                 pc_write_en,
   output logic                 fd_write_en,
   output logic                 fd_flush,
   output logic                 de_flush,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_events,
   output logic [1:0]           ctrl_state
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   ctrl_state_e            state_q, state_n;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_n;
   logic                   load_use;
   logic                   flush_inc;
   logic                   stall_inc;

   assign load_use = load_use_hit(ex_mem_read, ex_Rd, opcode_decode, Rs_decode, Rd_decode);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CTRL_RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_n;
         flush_cnt_q <= flush_cnt_n;
      end
   end

   // MEM_WAIT behaves exactly like RUN once memory releases, so both share
   // the RUN decode; FLUSH only ever redirects or freezes.
   always_comb begin
      state_n     = state_q;
      flush_cnt_n = flush_cnt_q;
      pc_write_en = 1'b1;
      fd_write_en = 1'b1;
      fd_flush    = 1'b0;
      de_flush    = 1'b0;
      flush_inc   = 1'b0;

      if (mem_busy) begin
         pc_write_en = 1'b0;
         fd_write_en = 1'b0;
         if (state_q != CTRL_FLUSH) begin
            state_n = CTRL_MEM_WAIT;
         end
      end else if (state_q == CTRL_FLUSH) begin
         fd_flush    = 1'b1;
         de_flush    = 1'b1;
         flush_cnt_n = flush_cnt_q - FLUSH_CNT_W'(1);
         if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_n = CTRL_RUN;
         end
      end else if (branch_taken) begin
         fd_flush  = 1'b1;
         de_flush  = 1'b1;
         flush_inc = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            flush_cnt_n = FLUSH_LOAD;
            state_n     = CTRL_FLUSH;
         end else begin
            state_n = CTRL_RUN;
         end
      end else if (load_use) begin
         pc_write_en = 1'b0;
         fd_write_en = 1'b0;
         de_flush    = 1'b1;
         state_n     = CTRL_RUN;
      end else begin
         state_n = CTRL_RUN;
      end

      // Reset loads bubbles into both pipeline registers and suppresses counting.
      if (rst) begin
         pc_write_en = 1'b0;
         fd_write_en = 1'b1;
         fd_flush    = 1'b1;
         de_flush    = 1'b1;
         flush_inc   = 1'b0;
      end
   end

   assign stall_inc  = ~pc_write_en & ~rst;
   assign ctrl_state = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (flush_inc),
      .count (flush_events)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with FLUSH_CYCLES=3 and narrow
// counters so saturation is reachable in a short run.
module tb_hazard_stall_ctrl;

   localparam int FC = 3;
   localparam int CW = 4;

   // ctrl vector = {pc_we, fd_we, fd_flush, de_flush, state[1:0]}
   localparam logic [5:0] C_NORM     = 6'b1100_00;
   localparam logic [5:0] C_NORM_MW  = 6'b1100_01;
   localparam logic [5:0] C_LU       = 6'b0001_00;
   localparam logic [5:0] C_FRZ_RUN  = 6'b0000_00;
   localparam logic [5:0] C_FRZ_MW   = 6'b0000_01;
   localparam logic [5:0] C_FRZ_FL   = 6'b0000_10;
   localparam logic [5:0] C_RDR_RUN  = 6'b1111_00;
   localparam logic [5:0] C_RDR_MW   = 6'b1111_01;
   localparam logic [5:0] C_RDR_FL   = 6'b1111_10;
   localparam logic [5:0] C_RST_RUN  = 6'b0111_00;
   localparam logic [5:0] C_RST_FL   = 6'b0111_10;

   typedef struct packed {
      logic       rst;
      logic [4:0] op;
      logic [2:0] rs;
      logic [2:0] rd;
      logic       mr;
      logic [2:0] exrd;
      logic       br;
      logic       mb;
      logic [5:0] ctrl;
      logic       cf;
   } stim_t;

   typedef struct packed {
      logic [5:0]    ctrl;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    opcode_decode;
   logic [2:0]    Rs_decode, Rd_decode, ex_Rd;
   logic          ex_mem_read, branch_taken, mem_busy;
   logic          pc_write_en, fd_write_en, fd_flush, de_flush;
   logic [CW-1:0] stall_cycles, flush_events;
   logic [1:0]    ctrl_state;
   logic [5:0]    ctrl_obs;

   exp_t          sb[$];
   logic [CW-1:0] m_stall, m_flush;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode_decode (opcode_decode),
      .Rs_decode     (Rs_decode),
      .Rd_decode     (Rd_decode),
      .ex_mem_read   (ex_mem_read),
      .ex_Rd         (ex_Rd),
      .branch_taken  (branch_taken),
      .mem_busy      (mem_busy),
      .pc_write_en   (pc_write_en),
      .fd_write_en   (fd_write_en),
      .fd_flush      (fd_flush),
      .de_flush      (de_flush),
      .stall_cycles  (stall_cycles),
      .flush_events  (flush_events),
      .ctrl_state    (ctrl_state)
   );

   assign ctrl_obs = {pc_write_en, fd_write_en, fd_flush, de_flush, ctrl_state};

   function automatic stim_t mk(input logic r, input logic [4:0] op, input logic [2:0] rs,
                                input logic [2:0] rd, input logic mr, input logic [2:0] exrd,
                                input logic br, input logic mb, input logic [5:0] ctrl,
                                input logic cf);
      stim_t s;
      s = '{rst: r, op: op, rs: rs, rd: rd, mr: mr, exrd: exrd, br: br, mb: mb, ctrl: ctrl, cf: cf};
      return s;
   endfunction

   // Drives one cycle of stimulus and queues what the DUT must show in it.
   // Counters seen this cycle reflect earlier cycles, so the model updates after the push.
   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      rst           = s.rst;
      opcode_decode = s.op;
      Rs_decode     = s.rs;
      Rd_decode     = s.rd;
      ex_mem_read   = s.mr;
      ex_Rd         = s.exrd;
      branch_taken  = s.br;
      mem_busy      = s.mb;
      sb.push_back('{ctrl: s.ctrl, stall: m_stall, flush: m_flush});
      if (s.rst) begin
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (!s.ctrl[5] && (m_stall != {CW{1'b1}})) m_stall = m_stall + 1'b1;
         if (s.cf && (m_flush != {CW{1'b1}})) m_flush = m_flush + 1'b1;
      end
   endtask

   task automatic test_reset();
      stim_t tbl[$];
      exp_t  e;
      rst = 1'b1; opcode_decode = 5'h00; Rs_decode = '0; Rd_decode = '0;
      ex_mem_read = 1'b0; ex_Rd = '0; branch_taken = 1'b0; mem_busy = 1'b0;
      @(posedge clk);
      m_stall = '0;
      m_flush = '0;
      tbl.push_back(mk(1, 5'h00, 0, 0, 0, 0, 0, 0, C_RST_RUN, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL reset[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL reset[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 5'h04, 3, 0, 1, 3, 0, 0, C_LU, 0));
      tbl.push_back(mk(0, 5'h04, 3, 0, 0, 3, 0, 0, C_NORM, 0));
      tbl.push_back(mk(0, 5'h00, 3, 0, 1, 3, 0, 0, C_NORM, 0));
      tbl.push_back(mk(0, 5'h04, 1, 3, 1, 3, 0, 0, C_LU, 0));
      tbl.push_back(mk(0, 5'h04, 1, 2, 1, 3, 0, 0, C_NORM, 0));
      tbl.push_back(mk(0, 5'h07, 5, 5, 0, 5, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL load_use[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL load_use[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   task automatic test_branch();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, C_RDR_RUN, 1));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      // Branch coincident with a load-use: redirect wins, hazard ignored while flushing.
      tbl.push_back(mk(0, 5'h04, 3, 0, 1, 3, 1, 0, C_RDR_RUN, 1));
      tbl.push_back(mk(0, 5'h04, 3, 0, 1, 3, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h04, 3, 0, 1, 3, 1, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL branch[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL branch[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   task automatic test_mem_busy_branch();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 1, C_FRZ_RUN, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 1, C_FRZ_MW, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, C_RDR_MW, 1));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL mem_busy_branch[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL mem_busy_branch[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   task automatic test_flush_freeze();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, C_RDR_RUN, 1));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, C_FRZ_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL flush_freeze[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL flush_freeze[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, C_RDR_RUN, 1));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_RDR_FL, 0));
      tbl.push_back(mk(1, 5'h00, 0, 0, 0, 0, 1, 0, C_RST_FL, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL reset_mid_flush[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL reset_mid_flush[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   // branch_taken held high: a new redirect every FC cycles, driving flush_events to saturation.
   task automatic test_back_to_back();
      stim_t tbl[$];
      exp_t  e;
      for (int k = 0; k < 18 * FC; k++) begin
         if (k % FC == 0) tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, C_RDR_RUN, 1));
         else             tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, C_RDR_FL, 0));
      end
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL back_to_back[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL back_to_back[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   task automatic test_stall_saturation();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, C_FRZ_RUN, 0));
      for (int k = 0; k < 19; k++) tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, C_FRZ_MW, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM_MW, 0));
      tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, C_NORM, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         #2;
         e = sb.pop_front();
         total++;
         if (ctrl_obs !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL stall_saturation[%0d] ctrl got=%b want=%b", i, ctrl_obs, e.ctrl);
         end
         total++;
         if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
            bad++;
            $display("[TB] FAIL stall_saturation[%0d] counters got=%0d/%0d want=%0d/%0d", i, stall_cycles, flush_events, e.stall, e.flush);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_busy_branch();
      test_flush_freeze();
      test_reset_mid_flush();
      test_back_to_back();
      test_stall_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline control unit that sequences the fetch/decode pipeline register, the PC and the decode/execute register of the five-stage processor. It detects load-use hazards, taken-branch redirects and multi-cycle memory stalls, and drives the write-enable and flush controls of those stages accordingly. It also keeps saturating performance counters for stall and flush activity.

## Interface
Parameters:
- FLUSH_CYCLES, 1, number of consecutive flush cycles issued per taken branch (1..15); covers instruction-memory refill latency.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode_decode  in  5  opcode of the instruction currently in decode.
- Rs_decode  in  3  first source register of the decode instruction.
- Rd_decode  in  3  second source/destination register of the decode instruction.
- ex_mem_read  in  1  instruction in execute is a load.
- ex_Rd  in  3  destination register of the execute instruction.
- branch_taken  in  1  branch resolved taken in execute this cycle.
- mem_busy  in  1  memory stage is not complete; whole pipeline must hold.
- pc_write_en  out  1  PC may update.
- fd_write_en  out  1  fetch/decode register may capture.
- fd_flush  out  1  fetch/decode register captures a NOP bubble.
- de_flush  out  1  decode/execute register captures a NOP bubble.
- stall_cycles  out  CNT_W  cycles with pc_write_en=0 since reset, saturating.
- flush_events  out  CNT_W  taken-branch redirects since reset, saturating.
- ctrl_state  out  2  current FSM state, for debug.

## Operation
- FSM states (encoding in package): RUN=0, MEM_WAIT=1, FLUSH=2.
- uses_src = (opcode_decode != OP_NOP). load_use = ex_mem_read & uses_src & (ex_Rd==Rs_decode | ex_Rd==Rd_decode).
- Priority in RUN: mem_busy > branch_taken > load_use > normal.
- RUN, mem_busy=1: freeze. pc_write_en=0, fd_write_en=0, fd_flush=0, de_flush=0. Next state MEM_WAIT.
- RUN, branch_taken=1: redirect. pc_write_en=1, fd_write_en=1, fd_flush=1, de_flush=1. flush_events +1. If FLUSH_CYCLES>1, load flush_cnt=FLUSH_CYCLES-1 and go to FLUSH; otherwise stay in RUN.
- RUN, load_use=1: one bubble. pc_write_en=0, fd_write_en=0, de_flush=1, fd_flush=0. Stay in RUN; the bubble clears ex_mem_read on the next cycle.
- RUN, normal: pc_write_en=1, fd_write_en=1, both flushes 0.
- MEM_WAIT, mem_busy=1: freeze as above.
- MEM_WAIT, mem_busy=0: outputs and next state exactly as RUN with the same inputs. A branch_taken held during the freeze is therefore acted on in the release cycle.
- FLUSH, mem_busy=1: freeze. flush_cnt holds and the state stays FLUSH.
- FLUSH, otherwise: outputs as a redirect but with no flush_events increment. branch_taken and load_use are ignored, because execute holds a bubble. flush_cnt decrements; when flush_cnt==1, go to RUN.
- stall_cycles increments on every cycle with pc_write_en=0 outside reset. Both counters saturate at all-ones.

## Timing
- Outputs are combinational from the registered state/flush_cnt and the current inputs (Mealy), valid within the same cycle. State, flush_cnt and counters update on rising clk.
- Redirect latency: 0 cycles from branch_taken to flushes. Total redirect flushes = FLUSH_CYCLES, plus any interleaved freeze cycles.
- Reset: when rst=1 at an edge, the state becomes RUN, flush_cnt=0 and both counters become 0. While rst=1, outputs are forced to pc_write_en=0, fd_write_en=1, fd_flush=1, de_flush=1, which loads bubbles. Reset mid-FLUSH or mid-MEM_WAIT abandons the sequence without a pending redirect.
- Simultaneous mem_busy and branch_taken: freeze wins and the branch is taken on release.
- Simultaneous branch_taken and load_use: redirect wins and no bubble is counted as a stall.

## Structure
- Shared package pipeline_ctrl_pkg holds the state enum/constants (CTRL_RUN, CTRL_MEM_WAIT, CTRL_FLUSH), OP_NOP=5'b00000, and the register-index width 3.
- One sub-module, sat_counter (parameter W, inputs inc/clr), is instantiated twice for the performance counters.
- The FSM, hazard compare and output decode live in the top module.

## Test plan
- Reset then idle (opcode NOP, all inputs 0): after reset the outputs are pc_write_en=1, fd_write_en=1, flushes 0, state RUN, counters 0.
- Load-use: ex_mem_read=1, ex_Rd=3, Rs_decode=3, opcode=5'h04 -> exactly one cycle of pc_write_en=0/de_flush=1, with stall_cycles=1. Repeat with opcode=NOP -> no stall.
- Branch with FLUSH_CYCLES=3: one-cycle branch_taken -> 3 consecutive cycles of fd_flush=de_flush=1 and pc_write_en=1, flush_events=1, then RUN.
- mem_busy high for 4 cycles with branch_taken also high -> 4 frozen cycles (stall_cycles=4), then a redirect on the release cycle.
- mem_busy pulse during the second FLUSH cycle (FLUSH_CYCLES=3) -> the flush sequence extends by one frozen cycle and still delivers 3 flush cycles.
- rst asserted mid-FLUSH -> next cycle the state is RUN, counters are 0, and no further flush cycles occur after rst drops.
